interval_sequencer: RTL
=======================

// Module: interval_sequencer
// PURPOSE
//  Upstream controller for the 6-bit timer. Holds a table of programmable intervals.
//  Presents one interval at a time on the timer compare input (tmr_c).
//  Clears the timer, waits for its expiry, then advances to the next phase.
//  Produces phase index, per-phase strobe and end-of-sequence strobe for downstream logic.
// PARAMETERS
//  DEPTH    8   number of interval table entries
//  ADDR_W   3   table index width; DEPTH = 2**ADDR_W
//  DATA_W   6   interval width; matches timer compare width
//  CLR_CYC  2   cycles tmr_rst is held low before each phase (>=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  wr_en       in   1       table write strobe
//  wr_addr     in   ADDR_W  table write index
//  wr_data     in   DATA_W  interval value
//  last_idx    in   ADDR_W  index of final phase; sampled at start
//  start       in   1       begin sequence; one-cycle pulse, IDLE only
//  abort       in   1       terminate sequence
//  tmr_expire  in   1       timer expiry level, active-high, clk domain
//  tmr_c       out  DATA_W  compare value driven to timer
//  tmr_rst     out  1       timer clear, active-low
//  phase       out  ADDR_W  current phase index
//  busy        out  1       high in every state except IDLE
//  phase_pulse out  1       1-cycle strobe at end of each phase
//  done        out  1       1-cycle strobe at sequence completion
// BEHAVIOUR
//  Reset values: tmr_c=0, tmr_rst=0, phase=0, busy=0, phase_pulse=0, done=0.
//    Table contents are all 0. State is IDLE.
//  FSM states and transitions:
//    IDLE  -> LOAD on start. Latch last_idx; phase=0.
//    LOAD  -> tmr_c<=tbl[phase], tmr_rst=0.
//             If tbl[phase]==0, go to NEXT (phase skipped, timer never run).
//             Otherwise go to CLEAR.
//    CLEAR -> hold tmr_rst=0 for CLR_CYC cycles including LOAD, then go to RUN.
//    RUN   -> tmr_rst=1. Wait for a rising edge of tmr_expire (registered prev-sample).
//             The edge register is cleared in CLEAR, so expire high at RUN entry
//             does not count.
//    NEXT  -> phase_pulse=1 for one cycle.
//             If phase==last_idx, go to DONE. Otherwise phase++ and go to LOAD.
//    DONE  -> done=1 for one cycle, tmr_rst=0, then go to IDLE. phase holds its last value.
//  Latency:
//    start to first tmr_rst release = CLR_CYC+1 cycles.
//    Expire edge to phase_pulse = 1 cycle.
//  abort: any non-IDLE state goes to IDLE next cycle, with tmr_rst=0 and no
//    done/phase_pulse. abort+start in the same cycle: abort wins.
//  start while busy: ignored.
//  Writes are accepted in any state. A write to the active phase takes effect only
//    at that phase's next LOAD. tmr_c is registered and stable through RUN.
//  last_idx is captured at start. Changes during busy are ignored.
//  Reset asserted mid-sequence returns all outputs to reset values immediately.
// CONFIGURATION
//  SEQ_LOOP_EN defined:
//    - At phase==last_idx, NEXT goes to LOAD with phase=0.
//    - done pulses once per completed pass.
//    - The sequence runs until abort.
//  SEQ_LOOP_EN undefined: one-shot as above. The busy-to-IDLE transition follows done.
// STRUCTURE
//  Shared package/header seq_defs.vh:
//    - state encodings S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_NEXT, S_DONE (3-bit)
//    - default widths DATA_W=6, ADDR_W=3
//  Sub-module interval_regfile:
//    - DEPTH x DATA_W array with one write port and one async read port
//    - async active-low clear
//  The top level holds the FSM, CLR_CYC counter, expire edge detect and output registers.
// TESTING
//  1. Write tbl={5,3,7}, last_idx=2, start. Model the timer to expire after tmr_c cycles.
//     -> tmr_c sequence 5,3,7; three phase_pulse strobes; phase 0,1,2; one done;
//        busy falls the cycle after done.
//  2. tbl[1]=0, last_idx=2 -> phase 1 skipped without tmr_rst release; phase_pulse still
//     emitted; tmr_c goes 5,0,7.
//  3. abort asserted in RUN of phase 1 -> next cycle: busy=0, tmr_rst=0,
//     no done, phase_pulse absent.
//  4. tmr_expire held high across CLEAR into RUN -> no advance until it falls and rises again.
//  5. Pulse start during RUN; write tbl[0]=9 during phase 0 -> start ignored;
//     phase 0 keeps tmr_c=5.
//  6. SEQ_LOOP_EN, last_idx=1 -> phases 0,1,0,1...; done after each pass; stops only on abort.
//     Reset low mid-phase -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/interval_sequencer_pkg.sv
// Shared definitions for the interval sequencer: FSM state encoding,
// default widths and a small edge-detect helper.
package interval_sequencer_pkg;

    localparam int SEQ_ADDR_W_DEF  = 3;
    localparam int SEQ_DATA_W_DEF  = 6;
    localparam int SEQ_DEPTH_DEF   = 2 ** SEQ_ADDR_W_DEF;
    localparam int SEQ_CLR_CYC_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    // Rising edge from the current level and the previous-cycle sample.
    function automatic logic rise_det(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/interval_regfile.sv
// Interval table: DEPTH x DATA_W, one synchronous write port, one
// asynchronous read port, cleared to zero by the active-low reset.
module interval_regfile #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Table storage: cleared on reset, written whenever wr_en is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/interval_sequencer.sv
// Interval sequencer: steps a 6-bit timer through a table of compare values.
// Each phase loads tmr_c, holds the timer in clear for CLR_CYC cycles,
// releases it and waits for a rising edge on tmr_expire.
// Optional build macro: SEQ_LOOP_EN -- wrap from last_idx back to phase 0
// forever (done pulses at each wrap) until abort.
module interval_sequencer
    import interval_sequencer_pkg::*;
#(
    parameter int DEPTH   = SEQ_DEPTH_DEF,
    parameter int ADDR_W  = SEQ_ADDR_W_DEF,
    parameter int DATA_W  = SEQ_DATA_W_DEF,
    parameter int CLR_CYC = SEQ_CLR_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic              start,
    input  logic              abort,
    input  logic              tmr_expire,
    output logic [DATA_W-1:0] tmr_c,
    output logic              tmr_rst,
    output logic [ADDR_W-1:0] phase,
    output logic              busy,
    output logic              phase_pulse,
    output logic              done
);

    localparam int CNT_W = $clog2(CLR_CYC + 1);

    seq_state_e        state, state_nx;
    logic [ADDR_W-1:0] phase_nx;
    logic [ADDR_W-1:0] last_q, last_nx;
    logic [CNT_W-1:0]  clr_cnt, clr_cnt_nx;
    logic [DATA_W-1:0] tmr_c_nx;
    logic [DATA_W-1:0] tbl_rd;
    logic              done_nx;
    logic              exp_prev;
    logic              exp_rise;

    interval_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_tbl (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (phase),
        .rd_data (tbl_rd)
    );

    // exp_prev follows the live level in every state, so a level that is
    // already high when RUN begins is history, not an edge.
    assign exp_rise = rise_det(tmr_expire, exp_prev);

    // State, phase bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            phase       <= '0;
            last_q      <= '0;
            clr_cnt     <= '0;
            exp_prev    <= 1'b0;
            tmr_c       <= '0;
            tmr_rst     <= 1'b0;
            busy        <= 1'b0;
            phase_pulse <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            last_q      <= last_nx;
            clr_cnt     <= clr_cnt_nx;
            exp_prev    <= tmr_expire;
            tmr_c       <= tmr_c_nx;
            tmr_rst     <= (state_nx == S_RUN);
            busy        <= (state_nx != S_IDLE);
            phase_pulse <= (state_nx == S_NEXT);
            done        <= done_nx;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        last_nx    = last_q;
        clr_cnt_nx = clr_cnt;
        tmr_c_nx   = tmr_c;
        done_nx    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nx = S_LOAD;
                    phase_nx = '0;
                    last_nx  = last_idx;
                end
            end
            S_LOAD: begin
                // LOAD itself is the first cycle of the clear window.
                tmr_c_nx   = tbl_rd;
                clr_cnt_nx = CNT_W'(1);
                if (tbl_rd == '0) begin
                    state_nx = S_NEXT;
                end else if (CLR_CYC <= 1) begin
                    state_nx = S_RUN;
                end else begin
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_cnt >= CNT_W'(CLR_CYC - 1)) begin
                    state_nx = S_RUN;
                end else begin
                    clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (exp_rise) begin
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                if (phase == last_q) begin
`ifdef SEQ_LOOP_EN
                    state_nx = S_LOAD;
                    phase_nx = '0;
                    done_nx  = 1'b1;
`else
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
`endif
                end else begin
                    state_nx = S_LOAD;
                    phase_nx = phase + 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (abort && (state != S_IDLE)) begin
            state_nx = S_IDLE;
            done_nx  = 1'b0;
        end
    end

endmodule
